// File: rtl/register_file_sb_if.sv
// Decode/writeback side of the register file: read ports, write port, reservation and bulk clear.
// Every command (WEN, rsv_en, clr_req) is a one-cycle strobe taken at CLK rise; there is no ready, and commands are dropped while clr_busy is high.
interface register_file_sb_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic              WEN;
    logic [SEL_W-1:0]  wsel;
    logic [DATA_W-1:0] wdat;
    logic [SEL_W-1:0]  rsel1;
    logic [SEL_W-1:0]  rsel2;
    logic [DATA_W-1:0] rdat1;
    logic [DATA_W-1:0] rdat2;
    logic              busy1;
    logic              busy2;
    logic              rsv_en;
    logic [SEL_W-1:0]  rsv_sel;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output WEN, wsel, wdat, rsel1, rsel2, rsv_en, rsv_sel, clr_req,
        input  rdat1, rdat2, busy1, busy2, clr_busy
    );

    modport slave (
        input  WEN, wsel, wdat, rsel1, rsel2, rsv_en, rsv_sel, clr_req,
        output rdat1, rdat2, busy1, busy2, clr_busy
    );
endinterface

// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, RAW scoreboard and a sequenced bulk-clear engine.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding on both read ports.
module register_file_sb #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int ZERO_REG = 1
) (
    input  logic               CLK,
    input  logic               nRST,
    register_file_sb_if.slave  rf,
    output logic               dbg_state_o
);
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  ptr_q;
    logic              clr_busy_q;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    function automatic logic is_zero(input logic [SEL_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Terminal compare on the last index ends the sweep before the pointer could wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rf.clr_req) begin
                        state_q    <= CLEAR;
                        ptr_q      <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr_q == LAST_IDX) begin
                        state_q    <= IDLE;
                        ptr_q      <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ptr_q      <= '0;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Reserve is applied after the write so a same-index reserve leaves the entry busy.
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        if (state_q == CLEAR) begin
            regs_d[ptr_q] = '0;
            sb_d[ptr_q]   = 1'b0;
        end else begin
            if (rf.WEN && !is_zero(rf.wsel)) begin
                regs_d[rf.wsel] = rf.wdat;
                sb_d[rf.wsel]   = 1'b0;
            end
            if (rf.rsv_en && !is_zero(rf.rsv_sel)) begin
                sb_d[rf.rsv_sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            sb_q <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = rf.WEN && !is_zero(rf.wsel) && (state_q == IDLE);
`endif

    always_comb begin
        rf.rdat1 = is_zero(rf.rsel1) ? '0 : regs_q[rf.rsel1];
        rf.busy1 = !is_zero(rf.rsel1) && sb_q[rf.rsel1];
        rf.rdat2 = is_zero(rf.rsel2) ? '0 : regs_q[rf.rsel2];
        rf.busy2 = !is_zero(rf.rsel2) && sb_q[rf.rsel2];
`ifdef REGFILE_BYPASS_EN
        if (fwd_ok && (rf.wsel == rf.rsel1)) begin
            rf.rdat1 = rf.wdat;
            rf.busy1 = 1'b0;
        end
        if (fwd_ok && (rf.wsel == rf.rsel2)) begin
            rf.rdat2 = rf.wdat;
            rf.busy2 = 1'b0;
        end
`endif
    end

    assign rf.clr_busy  = clr_busy_q;
    assign dbg_state_o  = (state_q == CLEAR);
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus random traffic against an array-based reference model.
// Build with +define+REGFILE_BYPASS_EN to exercise the forwarding configuration.
module tb_register_file_sb;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;
    localparam int SEL_W    = $clog2(NUM_REGS);

    logic CLK;
    logic nRST;
    logic dbg_state;

    register_file_sb_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) bus ();

    register_file_sb #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ZERO_REG(1)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .rf          (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    // reference model
    logic [DATA_W-1:0] m_reg [NUM_REGS];
    logic              m_sb  [NUM_REGS];
    int                clr_left;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_reg[i] = '0;
            m_sb[i]  = 1'b0;
        end
        clr_left = 0;
    endtask

    // driver: one clock of stimulus, read-port check before the edge, model update at the edge
    task automatic step(input logic wen, input logic [SEL_W-1:0] ws, input logic [DATA_W-1:0] wd,
                        input logic rv, input logic [SEL_W-1:0] rs, input logic clr,
                        input logic [SEL_W-1:0] r1, input logic [SEL_W-1:0] r2);
        logic [DATA_W-1:0] e1, e2;
        logic b1, b2;
        int idx;
        bus.WEN = wen; bus.wsel = ws; bus.wdat = wd;
        bus.rsv_en = rv; bus.rsv_sel = rs; bus.clr_req = clr;
        bus.rsel1 = r1; bus.rsel2 = r2;
        #1;
        e1 = m_reg[r1]; b1 = m_sb[r1];
        e2 = m_reg[r2]; b2 = m_sb[r2];
`ifdef REGFILE_BYPASS_EN
        if (wen && ws != 0 && clr_left == 0) begin
            if (ws == r1) begin e1 = wd; b1 = 1'b0; end
            if (ws == r2) begin e2 = wd; b2 = 1'b0; end
        end
`endif
        check("rdat1", bus.rdat1, e1);
        check("busy1", bus.busy1, b1);
        check("rdat2", bus.rdat2, e2);
        check("busy2", bus.busy2, b2);
        check("clr_busy", bus.clr_busy, clr_left > 0);
        @(posedge CLK);
        if (clr_left > 0) begin
            idx = NUM_REGS - clr_left;
            m_reg[idx] = '0;
            m_sb[idx]  = 1'b0;
            clr_left--;
        end else begin
            if (wen && ws != 0) begin
                m_reg[ws] = wd;
                m_sb[ws]  = 1'b0;
            end
            if (rv && rs != 0) m_sb[rs] = 1'b1;
            if (clr) clr_left = NUM_REGS;
        end
        #1;
    endtask

    task automatic idle(input logic [SEL_W-1:0] r1, input logic [SEL_W-1:0] r2);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, r1, r2);
    endtask

    task automatic peek(input logic [SEL_W-1:0] r1, input logic [SEL_W-1:0] r2);
        bus.WEN = 1'b0; bus.rsv_en = 1'b0; bus.clr_req = 1'b0;
        bus.rsel1 = r1; bus.rsel2 = r2;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        bus.WEN = 1'b0; bus.rsv_en = 1'b0; bus.clr_req = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus.rsel1 = SEL_W'(i);
            bus.rsel2 = SEL_W'(NUM_REGS - 1 - i);
            #1;
            check({tag, "_rdat1"}, bus.rdat1, 0);
            check({tag, "_rdat2"}, bus.rdat2, 0);
            check({tag, "_busy1"}, bus.busy1, 0);
            check({tag, "_busy2"}, bus.busy2, 0);
        end
        check({tag, "_clr_busy"}, bus.clr_busy, 0);
    endtask

    task automatic fill_regs();
        for (int i = 1; i < NUM_REGS; i++) begin
            step(1'b1, SEL_W'(i), DATA_W'($urandom_range(1, 16'hFFFF)),
                 1'b1, SEL_W'(i - 1), 1'b0, SEL_W'(i), SEL_W'(i - 1));
        end
    endtask

    int n_busy;

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        nRST = 1'b0;
        bus.WEN = 1'b0; bus.wsel = '0; bus.wdat = '0;
        bus.rsel1 = '0; bus.rsel2 = '0;
        bus.rsv_en = 1'b0; bus.rsv_sel = '0; bus.clr_req = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check_all_zero("reset");
        @(posedge CLK);
        #1;

        // write then read back
        step(1'b1, 4'd3, 16'hBEEF, 1'b0, '0, 1'b0, 4'd3, 4'd0);
        peek(4'd3, 4'd3);
        check("wr_next", bus.rdat1, 16'hBEEF);

        // reservation, release by write, reserve wins on collision
        step(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, 4'd5, 4'd3);
        peek(4'd5, 4'd5);
        check("rsv_busy", bus.busy1, 1);
        step(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, 4'd5, 4'd3);
        peek(4'd5, 4'd5);
        check("rsv_again", bus.busy1, 1);
        step(1'b1, 4'd5, 16'h0A0A, 1'b0, '0, 1'b0, 4'd5, 4'd5);
        peek(4'd5, 4'd5);
        check("wr_release", bus.busy1, 0);
        step(1'b1, 4'd5, 16'h5A5A, 1'b1, 4'd5, 1'b0, 4'd5, 4'd3);
        peek(4'd5, 4'd5);
        check("rsv_wins_busy", bus.busy1, 1);
        check("rsv_wins_data", bus.rdat1, 16'h5A5A);

        // hardwired zero register
        step(1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 1'b0, 4'd0, 4'd5);
        peek(4'd0, 4'd0);
        check("zero_rdat", bus.rdat1, 0);
        check("zero_busy", bus.busy1, 0);

        // bulk clear with dropped commands mid-sweep
        fill_regs();
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd1, 4'd2);
        n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.clr_busy) break;
            n_busy++;
            step(k == 5, 4'd2, 16'hFFFF, k == 6, 4'd9, k == 8, 4'd2, SEL_W'(k));
        end
        check("clr_len", n_busy, 16);
        check_all_zero("after_clear");
        @(posedge CLK);
        #1;

        // reset in the middle of a clear
        fill_regs();
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd8, 4'd15);
        for (int k = 0; k < 7; k++) idle(SEL_W'(k), SEL_W'(k + 8));
        nRST = 1'b0;
        #1;
        check("rst_mid_clr_busy", bus.clr_busy, 0);
        check_all_zero("rst_mid_clear");
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        step(1'b1, 4'd7, 16'hAAAA, 1'b0, '0, 1'b0, 4'd7, 4'd0);
        peek(4'd7, 4'd0);
        check("wr_after_rst", bus.rdat1, 16'hAAAA);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, NUM_REGS - 1)),
                 DATA_W'($urandom), 1'($urandom_range(0, 1)),
                 SEL_W'($urandom_range(0, NUM_REGS - 1)), $urandom_range(0, 40) == 0,
                 SEL_W'($urandom_range(0, NUM_REGS - 1)), SEL_W'($urandom_range(0, NUM_REGS - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
